// File: rtl/tracker_pkg.sv
// Shared types and constants for the handshake-signal timestamp trackers.
package tracker_pkg;

    typedef logic signed [31:0] timestamp_t;

    localparam timestamp_t TS_NOT_FOUND = -32'sd1;

endpackage

// File: rtl/signal_tracker_ring.sv
// Circular timestamp storage: one write port, every entry and valid bit exposed flat.
module signal_tracker_ring #(
    parameter int BUFFER_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [31:0]                  wr_data,
    output logic [BUFFER_WIDTH-1:0][31:0] entries,
    output logic [BUFFER_WIDTH-1:0]      valid
);

    localparam int PTR_W = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(BUFFER_WIDTH - 1);

    logic [PTR_W-1:0] wr_ptr;

    // Entry payloads are not reset; the valid bits alone gate visibility.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid  <= '0;
            wr_ptr <= '0;
        end else if (wr_en) begin
            entries[wr_ptr] <= wr_data;
            valid[wr_ptr]   <= 1'b1;
            wr_ptr          <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/signal_tracker.sv
// Logs counter values while tracked_signal is asserted and answers registered point/range queries.
// Build option SIGNAL_TRACKER_EDGE_ONLY_EN: log only the first cycle of each assertion.
import tracker_pkg::*;

module signal_tracker #(
    parameter int DATA_WIDTH   = 1,
    parameter int BUFFER_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [31:0]    counter,
    input  logic [DATA_WIDTH-1:0] tracked_signal,
    input  logic signed [31:0]    value_in,
    output logic [1:0][31:0]      time_out,
    input  logic [1:0][31:0]      range_in,
    output logic signed [31:0]    range_out
);

    logic                          active;
    logic                          log_en;
    logic [BUFFER_WIDTH-1:0][31:0] entries;
    logic [BUFFER_WIDTH-1:0]       valid;

    timestamp_t q_time;
    timestamp_t rng_start;
    timestamp_t rng_end;
    timestamp_t pt_min;
    logic       pt_found;
    logic       rng_hit;

    assign active    = |tracked_signal;
    assign q_time    = value_in;
    assign rng_start = range_in[1];
    assign rng_end   = range_in[0];

`ifdef SIGNAL_TRACKER_EDGE_ONLY_EN
    logic prev_active;

    always_ff @(posedge clk) begin
        if (!rst) prev_active <= 1'b0;
        else      prev_active <= active;
    end

    assign log_en = active & ~prev_active;
`else
    assign log_en = active;
`endif

    signal_tracker_ring #(
        .BUFFER_WIDTH(BUFFER_WIDTH)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (log_en),
        .wr_data (counter),
        .entries (entries),
        .valid   (valid)
    );

    // Searches see the pre-write buffer, so a same-edge sample is not yet visible.
    always_comb begin
        pt_found = 1'b0;
        pt_min   = TS_NOT_FOUND;
        rng_hit  = 1'b0;
        for (int i = 0; i < BUFFER_WIDTH; i++) begin
            if (valid[i] && ($signed(entries[i]) >= q_time)
                && (!pt_found || ($signed(entries[i]) < pt_min))) begin
                pt_found = 1'b1;
                pt_min   = $signed(entries[i]);
            end
            if (valid[i] && ($signed(entries[i]) >= rng_start)
                && ($signed(entries[i]) <= rng_end)) begin
                rng_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            time_out[1] <= TS_NOT_FOUND;
            time_out[0] <= '0;
            range_out   <= '0;
        end else begin
            time_out[1] <= pt_min;
            time_out[0] <= value_in;
            range_out   <= {31'b0, rng_hit};
        end
    end

endmodule

// File: tb/tb_signal_tracker.sv
// Randomized and directed bench for signal_tracker against a queue-based reference model.
module tb_signal_tracker;

    localparam int DW = 1;
    localparam int BW = 8;
    localparam logic [31:0] NF = 32'hFFFF_FFFF;

    logic                   clk = 1'b0;
    logic                   rst;
    logic signed [31:0]     counter;
    logic [DW-1:0]          tracked_signal;
    logic signed [31:0]     value_in;
    logic [1:0][31:0]       time_out;
    logic [1:0][31:0]       range_in;
    logic signed [31:0]     range_out;

    int tests = 0;
    int fails = 0;

    int log_q[$];
    bit prev_m;
    int exp_t0, exp_t1, exp_r;

    always #5 clk = ~clk;

    signal_tracker #(
        .DATA_WIDTH   (DW),
        .BUFFER_WIDTH (BW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .counter        (counter),
        .tracked_signal (tracked_signal),
        .value_in       (value_in),
        .time_out       (time_out),
        .range_in       (range_in),
        .range_out      (range_out)
    );

    // Drive one cycle, update the reference model at the edge, then settle past it.
    task automatic step(input bit r, input int cnt, input bit sig,
                        input int v, input int s, input int e);
        bit found;
        rst            = r;
        counter        = cnt;
        tracked_signal = DW'(sig);
        value_in       = v;
        range_in[1]    = s;
        range_in[0]    = e;
        @(posedge clk);
        if (!r) begin
            log_q.delete();
            prev_m = 1'b0;
            exp_t0 = 0;
            exp_t1 = -1;
            exp_r  = 0;
        end else begin
            exp_t0 = v;
            exp_t1 = -1;
            found  = 1'b0;
            exp_r  = 0;
            foreach (log_q[i]) begin
                if (log_q[i] >= v && (!found || log_q[i] < exp_t1)) begin
                    exp_t1 = log_q[i];
                    found  = 1'b1;
                end
                if (s <= log_q[i] && log_q[i] <= e) exp_r = 1;
            end
`ifdef SIGNAL_TRACKER_EDGE_ONLY_EN
            if (sig && !prev_m) log_q.push_back(cnt);
`else
            if (sig) log_q.push_back(cnt);
`endif
            prev_m = sig;
            if (log_q.size() > BW) void'(log_q.pop_front());
        end
        #1;
    endtask

    task automatic test_reset;
        step(1'b0, 0, 1'b0, 0, 0, -1);
        tests++;
        if (time_out[1] !== NF || time_out[0] !== 32'd0) begin
            fails++;
            $display("FAIL reset_time_out: got {%0d,%0d} want {-1,0}",
                     $signed(time_out[1]), $signed(time_out[0]));
        end
        tests++;
        if (range_out !== 32'sd0) begin
            fails++;
            $display("FAIL reset_range_out: got %0d want 0", range_out);
        end
    endtask

    task automatic test_point;
        step(1'b0, 0, 1'b0, 0, 0, -1);
        step(1'b1, 10, 1'b1, 0, 0, -1);
        for (int c = 11; c < 14; c++) step(1'b1, c, 1'b0, 0, 0, -1);
        step(1'b1, 14, 1'b1, 0, 0, -1);
        step(1'b1, 20, 1'b0, 12, 0, -1);
        tests++;
        if (time_out[1] !== 32'd14 || time_out[0] !== 32'd12) begin
            fails++;
            $display("FAIL point_12: got {%0d,%0d} want {14,12}",
                     $signed(time_out[1]), $signed(time_out[0]));
        end
        step(1'b1, 21, 1'b0, 15, 0, -1);
        tests++;
        if (time_out[1] !== NF || time_out[0] !== 32'd15) begin
            fails++;
            $display("FAIL point_15: got {%0d,%0d} want {-1,15}",
                     $signed(time_out[1]), $signed(time_out[0]));
        end
    endtask

    task automatic test_range;
        int s_tab[4] = '{11, 11, 14, 15};
        int e_tab[4] = '{14, 13, 14, 11};
        int r_tab[4] = '{1, 0, 1, 0};
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 22 + k, 1'b0, 0, s_tab[k], e_tab[k]);
            tests++;
            if (range_out !== r_tab[k]) begin
                fails++;
                $display("FAIL range_%0d_%0d: got %0d want %0d",
                         s_tab[k], e_tab[k], range_out, r_tab[k]);
            end
        end
    endtask

    task automatic test_wrap;
        step(1'b0, 0, 1'b0, 0, 0, -1);
        for (int c = 0; c < 10; c++) step(1'b1, c, 1'b1, 100, 100, 99);
        step(1'b1, 10, 1'b0, 0, 0, 1);
        tests++;
        if (time_out[1] !== 32'd2) begin
            fails++;
            $display("FAIL wrap_point: got %0d want 2", $signed(time_out[1]));
        end
        tests++;
        if (range_out !== 32'sd0) begin
            fails++;
            $display("FAIL wrap_range: got %0d want 0", range_out);
        end
    endtask

    task automatic test_same_edge;
        step(1'b0, 0, 1'b0, 0, 0, -1);
        step(1'b1, 30, 1'b1, 30, 0, -1);
        tests++;
        if (time_out[1] !== NF) begin
            fails++;
            $display("FAIL same_edge: got %0d want -1", $signed(time_out[1]));
        end
        step(1'b1, 31, 1'b0, 30, 0, -1);
        tests++;
        if (time_out[1] !== 32'd30) begin
            fails++;
            $display("FAIL next_edge: got %0d want 30", $signed(time_out[1]));
        end
    endtask

    task automatic test_reset_mid;
        step(1'b0, 0, 1'b0, 0, 0, -1);
        for (int c = 5; c < 8; c++) step(1'b1, c, 1'b1, 0, 0, -1);
        step(1'b0, 8, 1'b0, 5, 0, 100);
        tests++;
        if (time_out[1] !== NF || time_out[0] !== 32'd0 || range_out !== 32'sd0) begin
            fails++;
            $display("FAIL reset_mid: got {%0d,%0d} r=%0d want {-1,0} r=0",
                     $signed(time_out[1]), $signed(time_out[0]), range_out);
        end
        step(1'b1, 9, 1'b0, 0, 0, 100);
        tests++;
        if (time_out[1] !== NF || range_out !== 32'sd0) begin
            fails++;
            $display("FAIL after_reset: got %0d r=%0d want -1 r=0",
                     $signed(time_out[1]), range_out);
        end
    endtask

    task automatic test_edge_only;
        logic [31:0] want;
`ifdef SIGNAL_TRACKER_EDGE_ONLY_EN
        want = NF;
`else
        want = 32'd41;
`endif
        step(1'b0, 0, 1'b0, 0, 0, -1);
        for (int c = 40; c <= 45; c++) step(1'b1, c, 1'b1, 0, 0, -1);
        step(1'b1, 46, 1'b0, 41, 40, 45);
        tests++;
        if (time_out[1] !== want) begin
            fails++;
            $display("FAIL held_point: got %0d want %0d",
                     $signed(time_out[1]), $signed(want));
        end
        tests++;
        if (range_out !== 32'sd1) begin
            fails++;
            $display("FAIL held_range: got %0d want 1", range_out);
        end
    endtask

    task automatic test_back_to_back;
        int cur = 100;
        int v, s, e;
        bit r, sig;
        step(1'b0, cur, 1'b0, 0, 0, -1);
        for (int n = 0; n < 400; n++) begin
            cur += int'($urandom_range(1, 3));
            r   = ($urandom_range(0, 99) != 0);
            sig = ($urandom_range(0, 2) != 0);
            v   = cur - int'($urandom_range(0, 30));
            s   = cur - int'($urandom_range(0, 30));
            e   = s + int'($urandom_range(0, 12)) - 3;
            step(r, cur, sig, v, s, e);
            tests++;
            if (time_out[1] !== exp_t1 || time_out[0] !== exp_t0) begin
                fails++;
                $display("FAIL rand_point[%0d]: got {%0d,%0d} want {%0d,%0d}", n,
                         $signed(time_out[1]), $signed(time_out[0]), exp_t1, exp_t0);
            end
            tests++;
            if (range_out !== exp_r) begin
                fails++;
                $display("FAIL rand_range[%0d]: got %0d want %0d", n, range_out, exp_r);
            end
        end
    endtask

    initial begin
        rst            = 1'b0;
        counter        = 0;
        tracked_signal = '0;
        value_in       = 0;
        range_in       = '0;
        test_reset();
        test_point();
        test_range();
        test_wrap();
        test_same_edge();
        test_reset_mid();
        test_edge_only();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
